tick_bcd_counter: RTL

- Multi-digit BCD up/down counter advanced by the divided clock that the clock divider produces on the 50 MHz system clock.
- The divided clock is not used as a clock. It is sampled as a level in the clk_in domain and edge-detected into a one-cycle step pulse.
- Feeds the seven-segment display path and stopwatch/timer logic with decimal digits, a step strobe and a wrap strobe.

---
 rtl/tick_bcd_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of a divided clock
// that is sampled as a level in the clk_in domain.
module tick_bcd_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_a_p,
  input  logic                  tick_src,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_bcd,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  step_p,
  output logic                  wrap_p
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam bit          SAT = (WRAP == 32'd0);

  logic [W-1:0] bcd_q, bcd_d;
  logic [W-1:0] bcd_inc, bcd_dec, ld_clamp;
  logic         tick_prev_q, tick_prev_d;
  logic         step_q, step_d;
  logic         wrap_q, wrap_d;
  logic         rise;
  logic         all_nine, all_zero, at_limit;
  logic         carry, borrow;

  assign rise        = tick_src & ~tick_prev_q;
  assign tick_prev_d = tick_src;

  // Increment/decrement candidates with full ripple, limit detect, load clamp.
  always_comb begin
    bcd_inc  = bcd_q;
    bcd_dec  = bcd_q;
    ld_clamp = ld_bcd;
    all_nine = 1'b1;
    all_zero = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (bcd_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      if (ld_bcd[4*i +: 4] > 4'd9) ld_clamp[4*i +: 4] = 4'd9;
    end
  end

  // Next count and strobes; clr beats ld beats a qualified rise.
  always_comb begin
    bcd_d    = bcd_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    at_limit = up_down ? all_nine : all_zero;
    if (clr) begin
      bcd_d = '0;
    end else if (ld) begin
      bcd_d = ld_clamp;
    end else if (rise && en) begin
      step_d = 1'b1;
      wrap_d = at_limit;
      if (!(at_limit && SAT)) begin
        bcd_d = up_down ? bcd_inc : bcd_dec;
      end
    end
  end

  // tick_prev resets high so a tick already high at release is not a rise.
  always_ff @(posedge clk_in or posedge rst_a_p) begin
    if (rst_a_p) begin
      bcd_q       <= '0;
      tick_prev_q <= 1'b1;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      bcd_q       <= bcd_d;
      tick_prev_q <= tick_prev_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bcd_out = bcd_q;
  assign step_p  = step_q;
  assign wrap_p  = wrap_q;

endmodule
